prod_accumulator: RTL and testbench
===================================

# prod_accumulator

Downstream stage of the serial 6x6 right-shift multiplier. Consumes each finished 12-bit unsigned product through a valid/ready handshake and accumulates a fixed number of products (N_TERMS) into a saturating ACC_W-bit sum. It presents the sum through a second valid/ready handshake, together with a sticky overflow flag. It is the accumulate half of the serial multiply-accumulate path.

## Interface
- N_TERMS, 20, products summed per result; legal range 1..255
- ACC_W, 16, accumulator and sum width; legal range 13..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- prod_in  in  12  unsigned product from the multiplier
- prod_valid  in  1  prod_in is final; upstream holds it until accepted
- prod_ready  out  1  block accepts a product this cycle
- clr  in  1  synchronous abort: discard partial sum and return to IDLE
- sum_out  out  ACC_W  accumulated (possibly saturated) sum
- sum_valid  out  1  sum_out and overflow hold a completed result
- sum_ready  in  1  consumer takes the result
- overflow  out  1  saturation occurred during this result
- term_cnt  out  8  products accepted in the current result

## Operation
- Clock and reset: single clock domain `clk`; asynchronous, active-low reset `rst`.
- States:
  - IDLE: acc=0, cnt=0.
  - ACC: partial sum held.
  - DONE: result presented.
- prod_ready = (state != DONE). It is decoded from state, so it is 1 from reset.
- Accept = prod_valid & prod_ready. If prod_valid is high while prod_ready is low, the product is ignored; upstream must keep holding it.
- On accept:
  - next = acc + zero-extended prod_in, computed at ACC_W+1 bits.
  - If bit ACC_W of next is set, acc = all-ones and overflow = 1 (sticky). Otherwise acc = next[ACC_W-1:0].
  - cnt = cnt+1.
- Transitions:
  - IDLE→ACC on accept when cnt+1 < N_TERMS.
  - ACC→ACC on accept while cnt+1 < N_TERMS.
  - IDLE/ACC→DONE on the accept that makes cnt+1 == N_TERMS. With N_TERMS=1 the block goes IDLE→DONE on the first accept.
  - DONE→IDLE on sum_valid & sum_ready. This clears acc, cnt and overflow.
- sum_valid = (state == DONE). sum_out = acc and is stable for the whole of DONE.
- Once saturated, acc stays at all-ones for further accepts in the same result.
- clr has priority over every other event, including accept and the output handshake in the same cycle. It forces IDLE and clears acc, cnt and overflow.
- Reset asserted mid-accumulation or in DONE immediately gives:
  - state=IDLE
  - sum_out=0, sum_valid=0, overflow=0, term_cnt=0
  - prod_ready=1
- No bubble is required: back-to-back accepts every cycle are legal in IDLE and ACC.

## Timing
- All state and outputs are registered except prod_ready and sum_valid, which are pure state decodes (no input-to-output combinational path).
- Reset values: sum_out=0, sum_valid=0, overflow=0, term_cnt=0, prod_ready=1.
- Latency: sum_valid rises on the clock edge that registers the N_TERMS-th accept, so it is visible the cycle after that accept.
- Minimum result period is N_TERMS+1 cycles: N_TERMS accept cycles plus one DONE cycle with sum_ready already high.
- A DONE handshake and a new prod_valid in the same cycle: the product is not accepted that cycle because prod_ready=0. It is accepted the next cycle in IDLE.
- term_cnt updates on the accept edge and reads N_TERMS throughout DONE.

## Test plan
- Reset: hold rst=0, then release. Required: prod_ready=1, sum_valid=0, sum_out=0, overflow=0, term_cnt=0.
- Basic sum, N_TERMS=4: feed 0x001, 0x010, 0x100, 0xFFF back to back with sum_ready=1. Required: sum_valid one cycle after the 4th accept, sum_out=0x1110, overflow=0, return to IDLE the next cycle.
- Saturation, default parameters: feed 20 x 0xFFF (true sum 81900). Required:
  - sum_out=0xFFFF and overflow=1.
  - Saturation first occurs on accept 17.
  - The next result, 20 x 0x001, gives sum_out=20, overflow=0.
- Backpressure: hold sum_ready=0 for 5 cycles in DONE while prod_valid=1 with 0x123. Required:
  - prod_ready=0 and sum_out stable throughout.
  - After sum_ready=1, 0x123 is accepted exactly once, in the first IDLE cycle.
- Abort: clr after 7 accepts, asserted in the same cycle as a prod_valid. Required: that product is not accepted, and term_cnt=0, sum_out=0, state IDLE.
- Mid-op reset: drive rst=0 asynchronously (between clock edges) during DONE. Required: sum_valid drops immediately with no clock edge, all outputs return to their reset values, and N_TERMS=1 passes 0x0AB through as sum_out=0x00AB.

Source files
------------

// File: rtl/prod_accumulator.sv
// Accumulates N_TERMS unsigned 12-bit products into a saturating sum,
// presented with a sticky overflow flag over a valid/ready handshake.
module prod_accumulator #(
    parameter int N_TERMS = 20,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             overflow,
    output logic [7:0]       term_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] NT = 9'(N_TERMS);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic             take;
    logic [8:0]       cnt_inc;
    logic [ACC_W:0]   next_sum;

    assign accept   = prod_valid & prod_ready;
    assign take     = sum_valid & sum_ready;
    assign cnt_inc  = {1'b0, term_cnt} + 9'd1;
    assign last     = (cnt_inc == NT);
    assign next_sum = {1'b0, sum_out} + (ACC_W+1)'(prod_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clr outranks both the accept and the result handshake
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        state_nxt = last ? DONE : ACC;
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        prod_ready = (state != DONE);
        sum_valid  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_out  <= '0;
            overflow <= 1'b0;
            term_cnt <= 8'd0;
        end else if (clr || take) begin
            sum_out  <= '0;
            overflow <= 1'b0;
            term_cnt <= 8'd0;
        end else if (accept) begin
            // carry out of the top bit pins the sum at all-ones
            if (next_sum[ACC_W]) begin
                sum_out  <= '1;
                overflow <= 1'b1;
            end else begin
                sum_out <= next_sum[ACC_W-1:0];
            end
            term_cnt <= cnt_inc[7:0];
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: three instances (N_TERMS 4, 20, 1) with
// a queue of expected results popped whenever a result is handed off.
module tb_prod_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_c;

    logic [11:0] a_p, b_p, c_p;
    logic a_v, b_v, c_v;
    logic a_pr, b_pr, c_pr;
    logic a_clr, b_clr, c_clr;
    logic [15:0] a_sum, b_sum, c_sum;
    logic a_sv, b_sv, c_sv;
    logic a_sr, b_sr, c_sr;
    logic a_ovf, b_ovf, c_ovf;
    logic [7:0] a_tc, b_tc, c_tc;

    int errs = 0;
    int checks = 0;

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];
    logic [16:0] ea, eb, ec;

    prod_accumulator #(.N_TERMS(4), .ACC_W(16)) u4 (
        .clk(clk), .rst(rst), .prod_in(a_p), .prod_valid(a_v),
        .prod_ready(a_pr), .clr(a_clr), .sum_out(a_sum),
        .sum_valid(a_sv), .sum_ready(a_sr), .overflow(a_ovf),
        .term_cnt(a_tc)
    );

    prod_accumulator u20 (
        .clk(clk), .rst(rst), .prod_in(b_p), .prod_valid(b_v),
        .prod_ready(b_pr), .clr(b_clr), .sum_out(b_sum),
        .sum_valid(b_sv), .sum_ready(b_sr), .overflow(b_ovf),
        .term_cnt(b_tc)
    );

    prod_accumulator #(.N_TERMS(1), .ACC_W(16)) u1 (
        .clk(clk), .rst(rst_c), .prod_in(c_p), .prod_valid(c_v),
        .prod_ready(c_pr), .clr(c_clr), .sum_out(c_sum),
        .sum_valid(c_sv), .sum_ready(c_sr), .overflow(c_ovf),
        .term_cnt(c_tc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitors: pop one expected result per completed handshake
    always @(negedge clk) begin
        if (a_sv && a_sr) begin
            if (qa.size() == 0) begin
                checks++; errs++;
                $display("FAIL a_unexpected: got %0h expected none", a_sum);
            end else begin
                ea = qa.pop_front();
                chk("a_sum", a_sum, ea[15:0]);
                chk("a_ovf", a_ovf, ea[16]);
            end
        end
        if (b_sv && b_sr) begin
            if (qb.size() == 0) begin
                checks++; errs++;
                $display("FAIL b_unexpected: got %0h expected none", b_sum);
            end else begin
                eb = qb.pop_front();
                chk("b_sum", b_sum, eb[15:0]);
                chk("b_ovf", b_ovf, eb[16]);
            end
        end
        if (c_sv && c_sr) begin
            if (qc.size() == 0) begin
                checks++; errs++;
                $display("FAIL c_unexpected: got %0h expected none", c_sum);
            end else begin
                ec = qc.pop_front();
                chk("c_sum", c_sum, ec[15:0]);
                chk("c_ovf", c_ovf, ec[16]);
            end
        end
    end

    // holds valid until the product is taken; leaves valid high
    task automatic send_b(input logic [11:0] p);
        int n;
        b_p = p;
        b_v = 1'b1;
        n = 0;
        while (!b_pr && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errs++;
            $display("FAIL b_send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rst_c = 1'b0;
        a_p = '0; b_p = '0; c_p = '0;
        a_v = 0; b_v = 0; c_v = 0;
        a_clr = 0; b_clr = 0; c_clr = 0;
        a_sr = 0; b_sr = 0; c_sr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pr", b_pr, 1);
        chk("rst_sv", b_sv, 0);
        chk("rst_sum", b_sum, 0);
        chk("rst_ovf", b_ovf, 0);
        chk("rst_tc", b_tc, 0);
        chk("rst_a_pr", a_pr, 1);
        chk("rst_c_sv", c_sv, 0);
        rst = 1'b1; rst_c = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_pr", b_pr, 1);

        // basic sum, N_TERMS=4
        a_sr = 1'b1;
        qa.push_back({1'b0, 16'h1110});
        a_v = 1'b1; a_p = 12'h001;
        @(posedge clk); #1; a_p = 12'h010;
        @(posedge clk); #1; a_p = 12'h100;
        @(posedge clk); #1;
        chk("a_sv_early", a_sv, 0);
        a_p = 12'hFFF;
        @(posedge clk); #1;
        a_v = 1'b0;
        chk("a_sv_latency", a_sv, 1);
        chk("a_tc_done", a_tc, 4);
        @(posedge clk); #1;
        chk("a_idle_sv", a_sv, 0);
        chk("a_idle_pr", a_pr, 1);
        chk("a_idle_tc", a_tc, 0);

        // saturation, defaults
        b_sr = 1'b1;
        qb.push_back({1'b1, 16'hFFFF});
        for (int i = 1; i <= 20; i++) begin
            send_b(12'hFFF);
            if (i == 16) begin
                chk("b_sum16", b_sum, 16'hFFF0);
                chk("b_ovf16", b_ovf, 0);
            end
            if (i == 17) begin
                chk("b_sum17", b_sum, 16'hFFFF);
                chk("b_ovf17", b_ovf, 1);
            end
        end
        b_v = 1'b0;
        chk("b_sat_sv", b_sv, 1);
        @(posedge clk); #1;
        chk("b_sat_idle", b_sv, 0);
        qb.push_back({1'b0, 16'd20});
        for (int i = 0; i < 20; i++) send_b(12'h001);
        b_v = 1'b0;
        @(posedge clk); #1;

        // backpressure
        b_sr = 1'b0;
        qb.push_back({1'b0, 16'd100});
        for (int i = 0; i < 20; i++) send_b(12'h005);
        b_p = 12'h123;
        b_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("b_bp_pr", b_pr, 0);
            chk("b_bp_sum", b_sum, 100);
            chk("b_bp_tc", b_tc, 20);
            @(posedge clk); #1;
        end
        b_sr = 1'b1;
        @(posedge clk); #1;
        chk("b_bp_idle_tc", b_tc, 0);
        chk("b_bp_idle_pr", b_pr, 1);
        @(posedge clk); #1;
        b_v = 1'b0;
        chk("b_bp_take_tc", b_tc, 1);
        chk("b_bp_take_sum", b_sum, 12'h123);
        @(posedge clk); #1;
        chk("b_bp_once", b_tc, 1);

        // abort after 7 accepts, clr alongside a valid product
        for (int i = 0; i < 6; i++) send_b(12'h001);
        chk("b_pre_clr_tc", b_tc, 7);
        b_p = 12'h055;
        b_v = 1'b1;
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        b_v = 1'b0;
        chk("b_clr_tc", b_tc, 0);
        chk("b_clr_sum", b_sum, 0);
        chk("b_clr_sv", b_sv, 0);
        chk("b_clr_pr", b_pr, 1);
        @(posedge clk); #1;
        chk("b_clr_hold", b_tc, 0);

        // async reset in DONE, then pass-through with N_TERMS=1
        c_sr = 1'b0;
        c_p = 12'h077;
        c_v = 1'b1;
        @(posedge clk); #1;
        c_v = 1'b0;
        chk("c_done_sv", c_sv, 1);
        chk("c_done_sum", c_sum, 16'h0077);
        chk("c_done_tc", c_tc, 1);
        #2 rst_c = 1'b0;
        #1;
        chk("c_arst_sv", c_sv, 0);
        chk("c_arst_pr", c_pr, 1);
        chk("c_arst_sum", c_sum, 0);
        chk("c_arst_tc", c_tc, 0);
        chk("c_arst_ovf", c_ovf, 0);
        #2 rst_c = 1'b1;
        @(posedge clk); #1;
        c_sr = 1'b1;
        qc.push_back({1'b0, 16'h00AB});
        c_p = 12'h0AB;
        c_v = 1'b1;
        @(posedge clk); #1;
        c_v = 1'b0;
        chk("c_pass_sv", c_sv, 1);
        @(posedge clk); #1;
        chk("c_pass_idle", c_sv, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
